pitch_frame_ctrl: RTL and testbench

PITCH_FRAME_CTRL -- requirements
Module: pitch_frame_ctrl

---
 rtl/pitch_frame_ctrl_if.sv | 28 ++
 rtl/pitch_frame_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pitch_frame_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pitch_frame_ctrl_if.sv
// Bus between the pitch frame controller and its FFT / peak-search engine.
//   fft_in_data/fft_in_valid/fft_in_last : frame samples, controller -> FFT
//   fft_in_ready                         : FFT accepts the current sample
//   peak/peak_k/peak_valid               : peak-search result, one-cycle strobe
// master = controller side, slave = FFT / peak-search side.
interface pitch_frame_ctrl_if #(
  parameter int DW    = 16,
  parameter int W     = 33,
  parameter int NBits = 10
);
  logic [DW-1:0]    fft_in_data;
  logic             fft_in_valid;
  logic             fft_in_last;
  logic             fft_in_ready;
  logic [W-1:0]     peak;
  logic [NBits-1:0] peak_k;
  logic             peak_valid;

  modport master (
    output fft_in_data, fft_in_valid, fft_in_last,
    input  fft_in_ready, peak, peak_k, peak_valid
  );

  modport slave (
    input  fft_in_data, fft_in_valid, fft_in_last,
    output fft_in_ready, peak, peak_k, peak_valid
  );
endinterface

// File: rtl/pitch_frame_ctrl.sv
// Pitch frame controller: collects NSamples audio samples into a frame buffer,
// streams the frame to an FFT, waits for the peak-search result and reports
// the strongest bin as the pitch estimate.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   enable             : run request
//   sample_in(_valid)  : audio sample stream
//   fft                : pitch_frame_ctrl_if master (FFT stream + peak result)
//   threshold          : voicing threshold (unsigned)
//   pitch_k/pitch_mag  : last reported bin / magnitude, pitch_valid strobe
//   voiced             : last report was at/above threshold
//   busy               : controller not idle
//   overrun            : sticky, a sample arrived while the buffer was in use
//   timeout_err        : one-cycle strobe, no peak result arrived in time
module pitch_frame_ctrl #(
  parameter int NSamples = 1024,
  parameter int DW       = 16,
  parameter int W        = 33,
  parameter int NBits    = $clog2(NSamples),
  parameter int TIMEOUT  = 8192
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [DW-1:0]    sample_in,
  input  logic             sample_in_valid,
  pitch_frame_ctrl_if.master fft,
  input  logic [W-1:0]     threshold,
  output logic [NBits-1:0] pitch_k,
  output logic [W-1:0]     pitch_mag,
  output logic             pitch_valid,
  output logic             voiced,
  output logic             busy,
  output logic             overrun,
  output logic             timeout_err
);

  localparam int WCW = $clog2(TIMEOUT) + 1;
  localparam logic [NBits-1:0] LAST_IDX  = NBits'(NSamples - 1);
  localparam logic [WCW-1:0]   WAIT_LAST = WCW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    STREAM,
    WAIT_PEAK,
    REPORT
  } state_t;

  state_t           state;
  logic [NBits-1:0] wr_cnt;
  logic [NBits-1:0] rd_cnt;
  logic [WCW-1:0]   wait_cnt;
  logic             buf_we;

  // Frame storage; contents are don't-care after reset, so no reset here.
  logic [DW-1:0] buffer [NSamples];

  // A sample is only taken while filling and still enabled: dropping enable
  // discards the sample presented in that same cycle.
  assign buf_we = (state == FILL) && enable && sample_in_valid;

  always_ff @(posedge clk) begin
    if (buf_we) begin
      buffer[wr_cnt] <= sample_in;
    end
  end

  // Combinational read so data follows rd_cnt directly; rd_cnt only moves on
  // a handshake, which keeps data/last stable while the FFT stalls.
  assign fft.fft_in_valid = (state == STREAM);
  assign fft.fft_in_data  = buffer[rd_cnt];
  assign fft.fft_in_last  = (state == STREAM) && (rd_cnt == LAST_IDX);
  assign busy             = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      wait_cnt    <= '0;
      pitch_k     <= '0;
      pitch_mag   <= '0;
      voiced      <= 1'b0;
      pitch_valid <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      pitch_valid <= 1'b0;
      timeout_err <= 1'b0;

      if (sample_in_valid &&
          (state == STREAM || state == WAIT_PEAK || state == REPORT)) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (enable) begin
            state  <= FILL;
            wr_cnt <= '0;
          end
        end

        FILL: begin
          if (!enable) begin
            state  <= IDLE;
            wr_cnt <= '0;
          end else if (sample_in_valid) begin
            if (wr_cnt == LAST_IDX) begin
              state  <= STREAM;
              wr_cnt <= '0;
              rd_cnt <= '0;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end

        // enable is ignored from here until the frame's result is resolved.
        STREAM: begin
          if (fft.fft_in_ready) begin
            if (rd_cnt == LAST_IDX) begin
              state    <= WAIT_PEAK;
              rd_cnt   <= '0;
              wait_cnt <= '0;
            end else begin
              rd_cnt <= rd_cnt + 1'b1;
            end
          end
        end

        // A result arriving on the final wait cycle still wins over timeout.
        WAIT_PEAK: begin
          if (fft.peak_valid) begin
            pitch_mag   <= fft.peak;
            pitch_k     <= fft.peak_k;
            voiced      <= (fft.peak >= threshold);
            pitch_valid <= 1'b1;
            state       <= REPORT;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_err <= 1'b1;
            wait_cnt    <= '0;
            wr_cnt      <= '0;
            state       <= enable ? FILL : IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        REPORT: begin
          wr_cnt <= '0;
          state  <= enable ? FILL : IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pitch_frame_ctrl.sv
module tb_pitch_frame_ctrl;
  localparam int N  = 8;
  localparam int TO = 16;
  localparam int DW = 16;
  localparam int W  = 33;
  localparam int NB = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [DW-1:0] sample_in;
  logic          sample_in_valid;
  logic [W-1:0]  threshold;
  logic [NB-1:0] pitch_k;
  logic [W-1:0]  pitch_mag;
  logic          pitch_valid;
  logic          voiced;
  logic          busy;
  logic          overrun;
  logic          timeout_err;

  always #5 clk = ~clk;

  pitch_frame_ctrl_if #(.DW(DW), .W(W), .NBits(NB)) bus ();

  pitch_frame_ctrl #(.NSamples(N), .DW(DW), .W(W), .TIMEOUT(TO)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .sample_in(sample_in),
    .sample_in_valid(sample_in_valid),
    .fft(bus),
    .threshold(threshold),
    .pitch_k(pitch_k),
    .pitch_mag(pitch_mag),
    .pitch_valid(pitch_valid),
    .voiced(voiced),
    .busy(busy),
    .overrun(overrun),
    .timeout_err(timeout_err)
  );

  // Scoreboard entries
  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } smp_t;

  typedef struct {
    logic [NB-1:0] k;
    logic [W-1:0]  mag;
    logic          v;
    int            cyc;
  } rep_t;

  smp_t exp_s[$];
  rep_t exp_r[$];
  int   exp_to[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int hs_count = 0;
  int rep_count = 0;
  int to_count = 0;

  // Reference state of the reported outputs
  logic [NB-1:0] m_k;
  logic [W-1:0]  m_mag;
  logic          m_v;
  logic          m_ovr;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void fail_ev(string nm);
    tests++;
    fails++;
    $display("FAIL %s: unexpected or missing event (cycle %0d)", nm, cyc);
  endfunction

  // Monitor: pops scoreboard whenever the DUT presents something
  smp_t        s;
  rep_t        r;
  int          t_exp;
  logic        prev_hold = 1'b0;
  logic [DW-1:0] hold_d;
  logic        hold_l;

  always @(negedge clk) begin
    if (bus.fft_in_valid) begin
      if (prev_hold) begin
        chk("hold_data", 64'(bus.fft_in_data), 64'(hold_d));
        chk("hold_last", 64'(bus.fft_in_last), 64'(hold_l));
      end
      if (bus.fft_in_ready) begin
        if (exp_s.size() == 0) begin
          fail_ev("fft_extra_handshake");
        end else begin
          s = exp_s.pop_front();
          chk("fft_data", 64'(bus.fft_in_data), 64'(s.data));
          chk("fft_last", 64'(bus.fft_in_last), 64'(s.last));
        end
        hs_count++;
      end
    end
    prev_hold = bus.fft_in_valid && !bus.fft_in_ready;
    hold_d    = bus.fft_in_data;
    hold_l    = bus.fft_in_last;

    if (pitch_valid) begin
      if (exp_r.size() == 0) begin
        fail_ev("pitch_valid_extra");
      end else begin
        r = exp_r.pop_front();
        chk("pitch_k", 64'(pitch_k), 64'(r.k));
        chk("pitch_mag", 64'(pitch_mag), 64'(r.mag));
        chk("voiced", 64'(voiced), 64'(r.v));
        chk("pitch_latency", 64'(cyc), 64'(r.cyc));
      end
      rep_count++;
    end

    if (timeout_err) begin
      if (exp_to.size() == 0) begin
        fail_ev("timeout_err_extra");
      end else begin
        t_exp = exp_to.pop_front();
        chk("timeout_cycle", 64'(cyc), 64'(t_exp));
        chk("timeout_no_pitch", 64'(pitch_valid), 64'(0));
      end
      to_count++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_fft_valid", 64'(bus.fft_in_valid), 64'(0));
    chk("rst_fft_last", 64'(bus.fft_in_last), 64'(0));
    chk("rst_pitch_valid", 64'(pitch_valid), 64'(0));
    chk("rst_pitch_k", 64'(pitch_k), 64'(0));
    chk("rst_pitch_mag", 64'(pitch_mag), 64'(0));
    chk("rst_voiced", 64'(voiced), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_overrun", 64'(overrun), 64'(0));
    chk("rst_timeout", 64'(timeout_err), 64'(0));
  endtask

  // Feed n samples while in FILL with random gaps. push: record as a frame.
  // glitch: stray peak_valid pulses that must be ignored outside WAIT_PEAK.
  task automatic fill(input int n, input bit push, input bit seq, input bit glitch);
    smp_t e;
    for (int i = 0; i < n; i++) begin
      int gap = $urandom_range(0, 2);
      repeat (gap) begin
        sample_in_valid = 1'b0;
        if (glitch && $urandom_range(0, 1) == 1) begin
          bus.peak_valid = 1'b1;
          bus.peak       = W'($urandom);
          bus.peak_k     = NB'($urandom);
        end
        tick();
        bus.peak_valid = 1'b0;
      end
      sample_in       = seq ? DW'(i + 1) : DW'($urandom);
      sample_in_valid = 1'b1;
      if (push) begin
        e.data = sample_in;
        e.last = (i == N - 1);
        exp_s.push_back(e);
      end
      tick();
    end
    sample_in_valid = 1'b0;
  endtask

  // One complete frame from IDLE. rmode: 0 ready=1, 1 random, 2 pattern 1,0,0,1
  task automatic do_frame(input int rmode, input bit seq, input bit to_mode,
                          input bit keep_en, input logic [W-1:0] pk,
                          input logic [NB-1:0] kk, input logic [W-1:0] thr,
                          input bit ovr);
    int   start, target, n, e_cyc;
    rep_t rr;
    threshold = thr;
    enable    = 1'b1;
    tick();
    fill(N, 1'b1, seq, 1'b1);

    start  = cyc;
    target = hs_count + N;
    n      = 0;
    while (hs_count < target && n < 200) begin
      case (rmode)
        0:       bus.fft_in_ready = 1'b1;
        1:       bus.fft_in_ready = 1'($urandom_range(0, 1));
        default: bus.fft_in_ready = (n % 4 == 0) || (n % 4 == 3);
      endcase
      sample_in_valid = ovr && (n == 1);
      sample_in       = DW'($urandom);
      tick();
      if (ovr && n == 1) m_ovr = 1'b1;
      n++;
    end
    bus.fft_in_ready = 1'b0;
    sample_in_valid  = 1'b0;
    if (n >= 200) fail_ev("stream_budget");
    if (rmode == 0) chk("stream_cycles", 64'(cyc - start), 64'(N));
    chk("busy_wait_peak", 64'(busy), 64'(1));

    e_cyc  = cyc;
    enable = keep_en;
    if (!to_mode) begin
      repeat ($urandom_range(0, 10)) tick();
      bus.peak       = pk;
      bus.peak_k     = kk;
      bus.peak_valid = 1'b1;
      rr.k   = kk;
      rr.mag = pk;
      rr.v   = (pk >= thr);
      rr.cyc = cyc + 1;
      exp_r.push_back(rr);
      m_k   = kk;
      m_mag = pk;
      m_v   = rr.v;
      tick();
      bus.peak_valid = 1'b0;
      target = rep_count + 1;
      n = 0;
      while (rep_count < target && n < 40) begin tick(); n++; end
      if (n >= 40) fail_ev("report_budget");
    end else begin
      exp_to.push_back(e_cyc + TO);
      target = to_count + 1;
      n = 0;
      while (to_count < target && n < 40) begin tick(); n++; end
      if (n >= 40) fail_ev("timeout_budget");
      chk("after_timeout_busy", 64'(busy), 64'(keep_en));
    end
    chk("hold_pitch_k", 64'(pitch_k), 64'(m_k));
    chk("hold_pitch_mag", 64'(pitch_mag), 64'(m_mag));
    chk("hold_voiced", 64'(voiced), 64'(m_v));
    chk("overrun", 64'(overrun), 64'(m_ovr));
    enable = 1'b0;
    tick();
    chk("idle_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    reset            = 1'b1;
    enable           = 1'b0;
    sample_in        = '0;
    sample_in_valid  = 1'b0;
    threshold        = '0;
    bus.fft_in_ready = 1'b0;
    bus.peak         = '0;
    bus.peak_k       = '0;
    bus.peak_valid   = 1'b0;
    m_k = '0; m_mag = '0; m_v = 1'b0; m_ovr = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    check_reset_outputs();

    // Sequential samples, continuous ready, voiced report
    do_frame(0, 1'b1, 1'b0, 1'b0, W'(100), NB'(3), W'(50), 1'b0);
    // Stalling FFT, pattern 1,0,0,1
    do_frame(2, 1'b0, 1'b0, 1'b0, W'(7), NB'(5), W'(7), 1'b0);
    // No peak result, enable held: timeout then FILL
    do_frame(1, 1'b0, 1'b1, 1'b1, '0, '0, W'(50), 1'b0);
    // Overrun during STREAM, then it must stick across the next frame
    do_frame(1, 1'b0, 1'b0, 1'b0, W'(40), NB'(6), W'(41), 1'b1);
    do_frame(1, 1'b0, 1'b0, 1'b1, W'(9), NB'(1), W'(2), 1'b0);

    // Abort partial frame after 5 samples; the sample on the abort cycle is lost
    enable = 1'b1;
    tick();
    fill(5, 1'b0, 1'b0, 1'b0);
    enable          = 1'b0;
    sample_in_valid = 1'b1;
    sample_in       = DW'($urandom);
    tick();
    sample_in_valid = 1'b0;
    repeat (3) tick();
    chk("abort_busy", 64'(busy), 64'(0));
    do_frame(1, 1'b0, 1'b0, 1'b0, W'(300), NB'(2), W'(299), 1'b0);

    // Reset in the middle of STREAM at rd_cnt=4
    enable = 1'b1;
    tick();
    fill(N, 1'b1, 1'b0, 1'b0);
    bus.fft_in_ready = 1'b1;
    begin
      int tgt = hs_count + 4;
      int n = 0;
      while (hs_count < tgt && n < 50) begin tick(); n++; end
      if (n >= 50) fail_ev("reset_stream_budget");
    end
    bus.fft_in_ready = 1'b0;
    reset  = 1'b1;
    enable = 1'b0;
    tick();
    reset = 1'b0;
    exp_s.delete();
    m_k = '0; m_mag = '0; m_v = 1'b0; m_ovr = 1'b0;
    check_reset_outputs();
    do_frame(1, 1'b0, 1'b0, 1'b0, W'(20), NB'(4), W'(50), 1'b0);

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      logic [W-1:0] pk, th;
      pk = {1'($urandom), 32'($urandom)};
      th = {1'($urandom), 32'($urandom)};
      do_frame($urandom_range(0, 2), 1'b0, ($urandom_range(0, 3) == 0),
               1'($urandom), pk, NB'($urandom), th, ($urandom_range(0, 3) == 0));
    end

    repeat (3) tick();
    chk("scoreboard_drained", 64'(exp_s.size() + exp_r.size() + exp_to.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
